hlsm_sample_loader: RTL and testbench

//   Upstream feeder for the max/min-difference HLSM.
//   - Captures a burst of DEPTH samples from a valid/ready stream into an internal register-file buffer.
//   - Pulses go for one cycle to launch the HLSM.
//   - Serves the HLSM's buffer reads through a combinational read port.
//   - Holds the buffer frozen until the HLSM signals done.

---
 rtl/hlsm_sample_loader.sv | 185 ++++++++++++++++++
 tb/tb_hlsm_sample_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hlsm_sample_loader.sv
// hlsm_sample_loader
//
// Upstream feeder for the max/min-difference HLSM. The block captures a burst
// of DEPTH samples from a valid/ready stream into a register-file buffer. It
// then pulses go for one cycle to launch the HLSM and serves the HLSM's buffer
// reads through a combinational read port. The buffer stays frozen until the
// HLSM reports done with a rising edge on done_in.
//
// Optional feature macro: LOADER_TIMEOUT_EN
//   defined   : a WAIT watchdog aborts to IDLE after TIMEOUT cycles and sets
//               the sticky err flag
//   undefined : no watchdog; WAIT holds until a done_in rise; err is tied 0
//
// Ports
//   Clk       in   1         system clock, rising edge
//   Rst       in   1         asynchronous active-low reset
//   start     in   1         request a new burst (honoured only in IDLE)
//   in_valid  in   1         upstream sample valid
//   in_data   in   WIDTH     upstream sample
//   in_ready  out  1         loader accepts a sample this cycle (FILL)
//   rd_addr   in   ADDR_W    HLSM read address
//   rd_data   out  WIDTH     mem[rd_addr], combinational; 0 when out of range
//   go        out  1         one-cycle launch pulse to the HLSM
//   done_in   in   1         HLSM done level
//   busy      out  1         high in every state except IDLE
//   count     out  ADDR_W+1  samples accepted in the current burst
//   err       out  1         sticky timeout flag
module hlsm_sample_loader #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              go,
    input  logic              done_in,
    output logic              busy,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_LAUNCH = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic               done_prev;
    logic               done_rise;
    logic               accept;
    logic               last_accept;
    logic               timeout_hit;

    assign accept      = (state_q == S_FILL) && in_valid;
    assign last_accept = accept && (wr_ptr == LAST_IDX);

    // done_prev resets high so that a done_in already high coming out of
    // reset is not mistaken for a fresh completion.
    assign done_rise = done_in && !done_prev;

    // All handshake outputs are pure decodes of the state register.
    assign in_ready = (state_q == S_FILL);
    assign go       = (state_q == S_LAUNCH);
    assign busy     = (state_q != S_IDLE);

    // Addresses beyond the buffer read as zero rather than aliasing.
    assign rd_data = ({1'b0, rd_addr} < DEPTH_EXT) ? mem[rd_addr] : '0;

`ifdef LOADER_TIMEOUT_EN
    localparam int                TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] wait_cnt;

    // The counter is zeroed while in LAUNCH, so it is zero on WAIT entry. The
    // abort fires on the edge that would complete TIMEOUT cycles in WAIT.
    assign timeout_hit = (state_q == S_WAIT) && (wait_cnt == TO_LAST);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wait_cnt <= '0;
        end else if (state_q == S_LAUNCH) begin
            wait_cnt <= '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // err is sticky until reset; a done rise on the same cycle wins.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            err <= 1'b0;
        end else if (timeout_hit && !done_rise) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Edge detector history, updated every cycle regardless of state.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            done_prev <= 1'b1;
        end else begin
            done_prev <= done_in;
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (last_accept) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Buffer write path. The write pointer saturates at the last entry, and
    // writes happen only in FILL, so the buffer is frozen in LAUNCH, WAIT
    // and IDLE. Count and contents persist in IDLE until the next start.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if ((state_q == S_IDLE) && start) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (accept) begin
            mem[wr_ptr] <= in_data;
            count       <= count + 1'b1;
            if (wr_ptr != LAST_IDX) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hlsm_sample_loader.sv
// tb_hlsm_sample_loader
//
// Self-checking bench for hlsm_sample_loader. A behavioural model tracks the
// burst phase, the captured samples and the done_in history. A compare
// process checks every DUT output against that model on each falling edge.
// Directed scenarios add hand-computed literal expectations. The timeout
// scenario runs when LOADER_TIMEOUT_EN is defined (TIMEOUT=10 here).
module tb_hlsm_sample_loader;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 10;

    localparam int P_IDLE   = 0;
    localparam int P_FILL   = 1;
    localparam int P_LAUNCH = 2;
    localparam int P_WAIT   = 3;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_ready;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [WIDTH-1:0]  rd_data;
    logic              go;
    logic              done_in = 1'b0;
    logic              busy;
    logic [ADDR_W:0]   count;
    logic              err;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    hlsm_sample_loader #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .go      (go),
        .done_in (done_in),
        .busy    (busy),
        .count   (count),
        .err     (err)
    );

    always #5 Clk = ~Clk;

    // Behavioural model state.
    int               m_phase;
    int               m_count;
    int               m_wait;
    bit               m_err;
    bit               m_done_prev;
    logic [WIDTH-1:0] m_mem [DEPTH];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, actual, expected);
        end
    endtask

    // Model update, mirroring the burst rules at the level of "how many
    // samples so far" and "has done risen since launch".
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_phase     = P_IDLE;
            m_count     = 0;
            m_wait      = 0;
            m_err       = 1'b0;
            m_done_prev = 1'b1;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else begin
            bit rise;
            rise = done_in && !m_done_prev;
            if (m_phase == P_IDLE) begin
                if (start) begin
                    m_phase = P_FILL;
                    m_count = 0;
                end
            end else if (m_phase == P_FILL) begin
                if (in_valid) begin
                    m_mem[m_count] = in_data;
                    m_count++;
                    if (m_count == DEPTH) m_phase = P_LAUNCH;
                end
            end else if (m_phase == P_LAUNCH) begin
                m_phase = P_WAIT;
                m_wait  = 0;
            end else begin
                if (rise) begin
                    m_phase = P_IDLE;
                end else begin
                    m_wait++;
`ifdef LOADER_TIMEOUT_EN
                    if (m_wait == TIMEOUT) begin
                        m_phase = P_IDLE;
                        m_err   = 1'b1;
                    end
`endif
                end
            end
            m_done_prev = done_in;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge Clk) begin
        if (checking) begin
            logic [WIDTH-1:0] exp_rd;
            exp_rd = (rd_addr < DEPTH) ? m_mem[rd_addr] : '0;
            checkOutput("go",       go,       m_phase == P_LAUNCH);
            checkOutput("in_ready", in_ready, m_phase == P_FILL);
            checkOutput("busy",     busy,     m_phase != P_IDLE);
            checkOutput("count",    count,    m_count);
            checkOutput("err",      err,      m_err);
            checkOutput("rd_data",  rd_data,  exp_rd);
        end
    end

    // One cycle of stimulus: inputs change 2 time units after a rising edge.
    task automatic applyStimulus(input bit s, input bit v,
                                 input logic [WIDTH-1:0] d, input bit dn);
        start    = s;
        in_valid = v;
        in_data  = d;
        done_in  = dn;
        rd_addr  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
        @(posedge Clk);
        #2;
    endtask

    // Start a burst and stream DEPTH samples. base >= 0 gives base, base+1..
    // with in_valid held high; base < 0 gives random data, random valid gaps
    // and random start noise. Returns two units after the edge following the
    // last accept, i.e. while go should be high.
    task automatic runBurst(input int base);
        int  accepted;
        int  guard;
        bit  v;
        bit  rdy;
        logic [WIDTH-1:0] d;
        applyStimulus(1'b1, 1'b0, '0, done_in);
        accepted = 0;
        guard    = 0;
        while (accepted < DEPTH && guard < 400) begin
            if (base >= 0) begin
                v = 1'b1;
                d = WIDTH'(base + accepted);
            end else begin
                v = 1'($urandom % 2);
                d = WIDTH'($urandom);
            end
            rdy = in_ready;
            applyStimulus((base < 0) ? 1'($urandom % 2) : 1'b0, v, d, done_in);
            if (v && rdy) accepted++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        checkOutput("fill_accepts", accepted, DEPTH);
    endtask

    initial begin
        Rst = 1'b1;
        #1 Rst = 1'b0;
        checking = 1'b1;

        // Reset state.
        repeat (2) @(posedge Clk);
        #2 Rst = 1'b1;
        checkOutput("rst_go",       go,       0);
        checkOutput("rst_busy",     busy,     0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_count",    count,    0);
        rd_addr = 5'd9;
        #1 checkOutput("rst_rd9", rd_data, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Burst of 3..18 with in_valid held high.
        runBurst(3);
        checkOutput("b1_go",    go,    1);
        checkOutput("b1_count", count, 16);
        rd_addr = 5'd5;
        #1 checkOutput("b1_rd5", rd_data, 8);
        rd_addr = 5'd20;
        #1 checkOutput("b1_rd20_oob", rd_data, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("b1_go_off",  go,       0);
        checkOutput("b1_waiting", busy,     1);
        checkOutput("b1_no_rdy",  in_ready, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("b1_done_idle", busy, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Burst with random valid gaps.
        runBurst(-1);
        checkOutput("b2_go", go, 1);
        applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0);
        checkOutput("b2_no_rdy", in_ready, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Stale done_in held high across launch.
        done_in = 1'b1;
        runBurst(40);
        repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("stale_done_busy", busy, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("fresh_done_idle", busy, 0);

        // Second start accepted, then reset mid-fill after 7 samples.
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("restart_busy", busy, 1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, WIDTH'(100 + i), 1'b0);
        checkOutput("pre_rst_count", count, 7);
        in_valid = 1'b0;
        Rst = 1'b0;
        rd_addr = 5'd2;
        #1;
        checkOutput("midrst_count", count,   0);
        checkOutput("midrst_busy",  busy,    0);
        checkOutput("midrst_rd2",   rd_data, 0);
        @(posedge Clk);
        #2 Rst = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // WAIT without any done_in rise.
        runBurst(-1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
`ifdef LOADER_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (busy && n < 40) begin
                applyStimulus(1'b0, 1'b0, '0, 1'b0);
                n++;
            end
            checkOutput("timeout_cycles", n,   TIMEOUT);
            checkOutput("timeout_err",    err, 1);
        end
`else
        repeat (3 * TIMEOUT) applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("hold_busy", busy, 1);
        checkOutput("hold_err",  err,  0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("hold_release", busy, 0);
`endif
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Random bursts with random done timing.
        for (int b = 0; b < 6; b++) begin
            runBurst(-1);
            repeat ($urandom_range(0, 5)) applyStimulus(1'b0, 1'b0, '0, 1'b0);
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b0, '0, 1'($urandom % 2));
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
        end

        repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
